// File: rtl/tmds_pkg.sv
// +----------------------------------------------------------------------------+
// | tmds_pkg: TMDS control tokens, alignment states and token detection.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  function automatic logic tmds_is_ctrl(input logic [9:0] word);
    return (word == TMDS_CTRL_00) || (word == TMDS_CTRL_01) ||
           (word == TMDS_CTRL_10) || (word == TMDS_CTRL_11);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_channel_decoder_if.sv
// +----------------------------------------------------------------------------+
// | tmds_channel_decoder_if: raw word input and decoded output bundle.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface tmds_channel_decoder_if;
  logic        raw_valid;
  logic [9:0]  raw_bits;
  logic        err_clear;
  logic        out_valid;
  logic        vde;
  logic [7:0]  vd;
  logic [1:0]  cd;
  logic        locked;
  logic [3:0]  bit_offset;
  logic [15:0] err_count;

  modport master (
    output raw_valid, raw_bits, err_clear,
    input  out_valid, vde, vd, cd, locked, bit_offset, err_count
  );

  modport slave (
    input  raw_valid, raw_bits, err_clear,
    output out_valid, vde, vd, cd, locked, bit_offset, err_count
  );
endinterface

`default_nettype wire

// File: rtl/tmds_word_decode.sv
// +----------------------------------------------------------------------------+
// | tmds_word_decode: combinational 10b -> 8b video / 2b control decode.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       is_ctrl,
  output logic [7:0] vd,
  output logic [1:0] cd
);

  logic [7:0] w_d;

  always_comb begin
    is_ctrl = tmds_is_ctrl(word);
    w_d     = word[9] ? ~word[7:0] : word[7:0];
    vd      = '0;
    cd      = 2'b00;
    if (is_ctrl) begin
      unique case (word)
        TMDS_CTRL_01: cd = 2'b01;
        TMDS_CTRL_10: cd = 2'b10;
        TMDS_CTRL_11: cd = 2'b11;
        default:      cd = 2'b00;
      endcase
    end else begin
      vd[0] = w_d[0];
      for (int i = 1; i < 8; i++) begin
        vd[i] = word[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tmds_channel_decoder.sv
// +----------------------------------------------------------------------------+
// | tmds_channel_decoder: token-based word alignment and TMDS decode.         |
// | Optional lock-loss counter: define TMDS_DECODER_ERR_CNT_EN.  Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int SEARCH_WORDS  = 16,
  parameter int VERIFY_TOKENS = 4,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  tmds_channel_decoder_if.slave bus
);

  localparam int DWELL_W = (SEARCH_WORDS  > 1) ? $clog2(SEARCH_WORDS)  : 1;
  localparam int VCNT_W  = (VERIFY_TOKENS > 1) ? $clog2(VERIFY_TOKENS) : 1;
  localparam int TMO_W   = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;

  align_state_t       r_state, w_state_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  logic [VCNT_W-1:0]  r_vcnt,  w_vcnt_nxt;
  logic [TMO_W-1:0]   r_tmo,   w_tmo_nxt;
  logic [3:0]         r_offset, w_offset_nxt;
  logic               w_lock_lost;

  logic [9:0]  r_prev, r_word;
  logic        r_word_valid;
  logic [9:0]  w_aligned;
  logic        w_is_ctrl;
  logic [7:0]  w_vd;
  logic [1:0]  w_cd;
  logic        r_out_valid, r_vde;
  logic [7:0]  r_vd;
  logic [1:0]  r_cd;

  function automatic logic [3:0] advance(input logic [3:0] off);
    return (off == 4'd9) ? 4'd0 : off + 4'd1;
  endfunction

  // The previous word sits in the low half, so offset k starts k bits into it.
  assign w_aligned = 10'({bus.raw_bits, r_prev} >> r_offset);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev       <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= bus.raw_valid;
      if (bus.raw_valid) begin
        r_prev <= bus.raw_bits;
        r_word <= w_aligned;
      end
    end
  end

  tmds_word_decode u_word_decode (
    .word    (r_word),
    .is_ctrl (w_is_ctrl),
    .vd      (w_vd),
    .cd      (w_cd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= SEARCH;
      r_dwell  <= '0;
      r_vcnt   <= '0;
      r_tmo    <= '0;
      r_offset <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dwell  <= w_dwell_nxt;
      r_vcnt   <= w_vcnt_nxt;
      r_tmo    <= w_tmo_nxt;
      r_offset <= w_offset_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dwell_nxt  = r_dwell;
    w_vcnt_nxt   = r_vcnt;
    w_tmo_nxt    = r_tmo;
    w_offset_nxt = r_offset;
    w_lock_lost  = 1'b0;
    if (r_word_valid) begin
      unique case (r_state)
        SEARCH: begin
          if (w_is_ctrl) begin
            w_state_nxt = VERIFY;
            w_vcnt_nxt  = VCNT_W'(1);
            w_dwell_nxt = '0;
          end else if (r_dwell == DWELL_W'(SEARCH_WORDS - 1)) begin
            w_dwell_nxt  = '0;
            w_offset_nxt = advance(r_offset);
          end else begin
            w_dwell_nxt = r_dwell + 1'b1;
          end
        end
        VERIFY: begin
          if (!w_is_ctrl) begin
            w_state_nxt  = SEARCH;
            w_offset_nxt = advance(r_offset);
            w_vcnt_nxt   = '0;
            w_dwell_nxt  = '0;
          end else if (r_vcnt == VCNT_W'(VERIFY_TOKENS - 1)) begin
            w_state_nxt = LOCKED;
            w_vcnt_nxt  = '0;
            w_tmo_nxt   = '0;
          end else begin
            w_vcnt_nxt = r_vcnt + 1'b1;
          end
        end
        LOCKED: begin
          if (w_is_ctrl) begin
            w_tmo_nxt = '0;
          end else if (r_tmo == TMO_W'(LOCK_TIMEOUT - 1)) begin
            w_state_nxt  = SEARCH;
            w_tmo_nxt    = '0;
            w_dwell_nxt  = '0;
            w_offset_nxt = advance(r_offset);
            w_lock_lost  = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo + 1'b1;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  // Qualifying with the next state keeps out_valid aligned with locked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_vde       <= 1'b0;
      r_vd        <= '0;
      r_cd        <= '0;
    end else begin
      r_out_valid <= r_word_valid && (w_state_nxt == LOCKED);
      if (r_word_valid) begin
        r_vde <= !w_is_ctrl;
        r_vd  <= w_vd;
        if (w_is_ctrl) r_cd <= w_cd;
      end
    end
  end

`ifdef TMDS_DECODER_ERR_CNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (bus.err_clear) begin
      r_err_count <= '0;
    end else if (w_lock_lost && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign bus.err_count = r_err_count;
`else
  logic w_unused_err_clear;
  assign w_unused_err_clear = bus.err_clear;
  assign bus.err_count      = '0;
`endif

  assign bus.out_valid  = r_out_valid;
  assign bus.vde        = r_vde;
  assign bus.vd         = r_vd;
  assign bus.cd         = r_cd;
  assign bus.locked     = (r_state == LOCKED);
  assign bus.bit_offset = r_offset;

endmodule

`default_nettype wire
